// File: rtl/serial_sub_unit_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_sub_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_unit_full_sub_bit.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, borrow held in a flop.
module serial_sub_unit
  import serial_sub_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Bit 0 of the result register would be shifted out before completion, so only WIDTH-1 bits are kept.
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] res_next;

  full_sub_bit u_cell (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  assign res_next = {cell_d, res_sr_q};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_next[WIDTH-1:1];
        borrow_d = cell_bo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = res_next;
          bout_d  = cell_bo;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed bench for serial_sub_unit (WIDTH=8): hand-computed differences, timing and hold checks.
module tb_serial_sub_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int   vectorCount = 0;
  int   missCount   = 0;
  bit   monitorArmed = 0;
  logic [7:0] prevDiff;
  logic       prevBout;

  serial_sub_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Runs one subtraction; optionally hammers start/a/b while the unit is shifting.
  task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                               input logic [7:0] expDiff, input logic expBout, input bit interfere);
    int busyCount;
    int extraDone;
    @(negedge clk);
    a = aIn;
    b = bIn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busyCount = 0;
    while (busy === 1'b1 && busyCount < 20) begin
      busyCount++;
      if (interfere && busyCount <= 3) begin
        start = 1'b1;
        a = 8'd1;
        b = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("busyCycles", busyCount, 8);
    checkOutput("donePulse", {31'd0, done}, 1);
    checkOutput("diff", {24'd0, diff}, {24'd0, expDiff});
    checkOutput("bout", {31'd0, bout}, {31'd0, expBout});
    extraDone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) extraDone++;
    end
    checkOutput("doneOnce", extraDone, 0);
    checkOutput("idleBusy", {31'd0, busy}, 0);
  endtask

  // Per-cycle checks after each posedge: reset clears outputs, done/busy exclusive, results held.
  always @(posedge clk) begin
    #2;
    if (rst === 1'b1) begin
      monitorArmed = 1'b1;
      checkOutput("rstDiff", {24'd0, diff}, 0);
      checkOutput("rstBout", {31'd0, bout}, 0);
    end else if (monitorArmed) begin
      checkOutput("doneBusyExcl", {31'd0, done & busy}, 0);
      if (done !== 1'b1) begin
        checkOutput("diffHold", {24'd0, diff}, {24'd0, prevDiff});
        checkOutput("boutHold", {31'd0, bout}, {31'd0, prevBout});
      end
    end
    prevDiff = diff;
    prevBout = bout;
  end

  initial begin
    int doneSeen;
    rst = 1'b1;
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", {31'd0, busy}, 0);
    checkOutput("resetDone", {31'd0, done}, 0);
    checkOutput("resetDiff", {24'd0, diff}, 0);
    checkOutput("resetBout", {31'd0, bout}, 0);
    rst = 1'b0;

    applyStimulus(8'd5,   8'd3,   8'd2,   1'b0, 1'b0);
    applyStimulus(8'd3,   8'd5,   8'd254, 1'b1, 1'b0);
    applyStimulus(8'd0,   8'd1,   8'd255, 1'b1, 1'b0);
    applyStimulus(8'd255, 8'd255, 8'd0,   1'b0, 1'b0);
    applyStimulus(8'd0,   8'd0,   8'd0,   1'b0, 1'b0);
    applyStimulus(8'd200, 8'd55,  8'd145, 1'b0, 1'b1);

    // Reset during the 4th shift cycle aborts the operation without a done pulse.
    @(negedge clk);
    a = 8'd9;
    b = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abortBusyBefore", {31'd0, busy}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortBusy", {31'd0, busy}, 0);
    checkOutput("abortDone", {31'd0, done}, 0);
    checkOutput("abortDiff", {24'd0, diff}, 0);
    checkOutput("abortBout", {31'd0, bout}, 0);
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("abortNoDone", doneSeen, 0);

    applyStimulus(8'd9, 8'd4, 8'd5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
